// File: rtl/vga_dither_332.sv
// 8-8-8 to 3-3-2 colour reduction with 4x4 ordered dithering and a two-stage pipeline; sync outputs are delayed to match it.
// Define VGA_DITHER_TEMPORAL_EN to rotate the dither pattern over four frames.
module vga_dither_332 #(
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET,
    input  logic       DITHER_ON,
    input  logic       VGA_HSYNC_IN,
    input  logic       VGA_VSYNC_IN,
    input  logic [7:0] VGA_RED_IN,
    input  logic [7:0] VGA_GREEN_IN,
    input  logic [7:0] VGA_BLUE_IN,
    output logic       VGA_HSYNC,
    output logic       VGA_VSYNC,
    output logic [2:0] VGA_RED,
    output logic [2:0] VGA_GREEN,
    output logic [1:0] VGA_BLUE
);

    logic [1:0] x_q, y_q;
    logic [1:0] px, py, lx, ly;
    logic       hs_edge, vs_edge;
    logic [3:0] th;

    logic       hs1_q, vs1_q;
    logic [7:0] r1_q, g1_q, b1_q;
    logic [3:0] th1_q;

    logic [3:0] r_top, g_top;
    logic [2:0] b_top;

    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] v;
        case ({row, col})
            4'd0:    v = 4'd0;
            4'd1:    v = 4'd8;
            4'd2:    v = 4'd2;
            4'd3:    v = 4'd10;
            4'd4:    v = 4'd12;
            4'd5:    v = 4'd4;
            4'd6:    v = 4'd14;
            4'd7:    v = 4'd6;
            4'd8:    v = 4'd3;
            4'd9:    v = 4'd11;
            4'd10:   v = 4'd1;
            4'd11:   v = 4'd9;
            4'd12:   v = 4'd15;
            4'd13:   v = 4'd7;
            4'd14:   v = 4'd13;
            default: v = 4'd5;
        endcase
        return v;
    endfunction

    // Stage-1 sync registers double as the previous-cycle history for edge detection.
    assign hs_edge = (VGA_HSYNC_IN == SYNC_ACTIVE) && (hs1_q != SYNC_ACTIVE);
    assign vs_edge = (VGA_VSYNC_IN == SYNC_ACTIVE) && (vs1_q != SYNC_ACTIVE);

    always_comb begin
        px = hs_edge ? 2'd0 : x_q + 2'd1;
        py = vs_edge ? 2'd0 : (hs_edge ? y_q + 2'd1 : y_q);
    end

`ifdef VGA_DITHER_TEMPORAL_EN
    logic [1:0] f_q, f_next;

    assign f_next = vs_edge ? f_q + 2'd1 : f_q;
    assign lx     = px + f_next;
    assign ly     = py + f_next;

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) f_q <= 2'd0;
        else       f_q <= f_next;
    end
`else
    assign lx = px;
    assign ly = py;
`endif

    assign th = DITHER_ON ? bayer(ly, lx) : 4'd0;

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            x_q   <= 2'd0;
            y_q   <= 2'd0;
            hs1_q <= ~SYNC_ACTIVE;
            vs1_q <= ~SYNC_ACTIVE;
            r1_q  <= 8'd0;
            g1_q  <= 8'd0;
            b1_q  <= 8'd0;
            th1_q <= 4'd0;
        end else begin
            x_q   <= px;
            y_q   <= py;
            hs1_q <= VGA_HSYNC_IN;
            vs1_q <= VGA_VSYNC_IN;
            r1_q  <= VGA_RED_IN;
            g1_q  <= VGA_GREEN_IN;
            b1_q  <= VGA_BLUE_IN;
            th1_q <= th;
        end
    end

    // Only the bits above the DAC resolution (plus carry) are kept; a set carry saturates.
    always_comb begin
        r_top = 4'(({1'b0, r1_q} + {4'b0, th1_q, 1'b0}) >> 5);
        g_top = 4'(({1'b0, g1_q} + {4'b0, th1_q, 1'b0}) >> 5);
        b_top = 3'(({1'b0, b1_q} + {3'b0, th1_q, 2'b0}) >> 6);
    end

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            VGA_HSYNC <= ~SYNC_ACTIVE;
            VGA_VSYNC <= ~SYNC_ACTIVE;
            VGA_RED   <= 3'd0;
            VGA_GREEN <= 3'd0;
            VGA_BLUE  <= 2'd0;
        end else begin
            VGA_HSYNC <= hs1_q;
            VGA_VSYNC <= vs1_q;
            VGA_RED   <= r_top[3] ? 3'b111 : r_top[2:0];
            VGA_GREEN <= g_top[3] ? 3'b111 : g_top[2:0];
            VGA_BLUE  <= b_top[2] ? 2'b11  : b_top[1:0];
        end
    end

endmodule

// File: tb/tb_vga_dither_332.sv
// Randomised bench for vga_dither_332: a driver pushes model predictions into a queue, a monitor pops and compares them.
module tb_vga_dither_332;

    localparam logic SA = 1'b0;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       DITHER_ON = 1'b1;
    logic       VGA_HSYNC_IN = ~SA;
    logic       VGA_VSYNC_IN = ~SA;
    logic [7:0] VGA_RED_IN = 8'd0;
    logic [7:0] VGA_GREEN_IN = 8'd0;
    logic [7:0] VGA_BLUE_IN = 8'd0;
    logic       VGA_HSYNC, VGA_VSYNC;
    logic [2:0] VGA_RED, VGA_GREEN;
    logic [1:0] VGA_BLUE;

    vga_dither_332 #(.SYNC_ACTIVE(SA)) dut (
        .CLK_25MHZ   (clk),
        .RESET       (RESET),
        .DITHER_ON   (DITHER_ON),
        .VGA_HSYNC_IN(VGA_HSYNC_IN),
        .VGA_VSYNC_IN(VGA_VSYNC_IN),
        .VGA_RED_IN  (VGA_RED_IN),
        .VGA_GREEN_IN(VGA_GREEN_IN),
        .VGA_BLUE_IN (VGA_BLUE_IN),
        .VGA_HSYNC   (VGA_HSYNC),
        .VGA_VSYNC   (VGA_VSYNC),
        .VGA_RED     (VGA_RED),
        .VGA_GREEN   (VGA_GREEN),
        .VGA_BLUE    (VGA_BLUE)
    );

    // Clock and cycle counter
    always #20 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected {hs, vs, r, g, b} and the cycle it must be visible in.
    logic [9:0] exp_q[$];
    int         due_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference model state
    int   bayer_tab[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    int   m_x = 0, m_y = 0;
    logic m_prev_hs = ~SA, m_prev_vs = ~SA;

    function automatic int reduce(input int c, input int th, input int scale, input int div);
        int s;
        s = c + scale * th;
        if (s > 255) s = 255;
        return s / div;
    endfunction

    task automatic drive(input logic rst, input logic hs, input logic vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic dith);
        logic hs_e, vs_e;
        int   px, py, th, er, eg, eb;
        @(negedge clk);
        RESET = rst;  VGA_HSYNC_IN = hs;  VGA_VSYNC_IN = vs;
        VGA_RED_IN = r;  VGA_GREEN_IN = g;  VGA_BLUE_IN = b;  DITHER_ON = dith;
        if (rst) begin
            // Anything still in flight is discarded; the next two output cycles are idle values.
            while (due_q.size() > 0 && due_q[$] > cyc) begin
                void'(due_q.pop_back());
                void'(exp_q.pop_back());
            end
            exp_q.push_back({~SA, ~SA, 3'd0, 3'd0, 2'd0});  due_q.push_back(cyc + 1);
            exp_q.push_back({~SA, ~SA, 3'd0, 3'd0, 2'd0});  due_q.push_back(cyc + 2);
            m_x = 0;  m_y = 0;  m_prev_hs = ~SA;  m_prev_vs = ~SA;
        end else begin
            hs_e = (hs == SA) && (m_prev_hs != SA);
            vs_e = (vs == SA) && (m_prev_vs != SA);
            px = hs_e ? 0 : (m_x + 1) % 4;
            py = vs_e ? 0 : (hs_e ? (m_y + 1) % 4 : m_y);
            th = dith ? bayer_tab[py][px] : 0;
            er = reduce(int'(r), th, 2, 32);
            eg = reduce(int'(g), th, 2, 32);
            eb = reduce(int'(b), th, 4, 64);
            exp_q.push_back({hs, vs, 3'(er), 3'(eg), 2'(eb)});
            due_q.push_back(cyc + 2);
            m_x = px;  m_y = py;  m_prev_hs = hs;  m_prev_vs = vs;
        end
    endtask

    task automatic pick_colour(input int mode, output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
        case (mode)
            0:       begin r = 8'h00; g = 8'h00; b = 8'h00; end
            1:       begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
            2:       begin r = 8'h10; g = 8'(($urandom_range(0, 7)) << 5); b = 8'h20; end
            3:       begin r = 8'hE0; g = 8'(($urandom_range(0, 3)) << 6); b = 8'hC0; end
            4:       begin r = 8'hFF - 8'($urandom_range(0, 40)); g = 8'($urandom_range(0, 255)); b = 8'hFF - 8'($urandom_range(0, 80)); end
            default: begin r = 8'($urandom_range(0, 255)); g = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); end
        endcase
    endtask

    // Short synthetic frame: hsync and vsync assert together at the first pixel.
    task automatic frame(input int mode, input int dmode, input int lines);
        logic [7:0] r, g, b;
        logic       d;
        for (int ln = 0; ln < lines; ln++) begin
            for (int p = 0; p < 20; p++) begin
                pick_colour(mode, r, g, b);
                d = (dmode == 2) ? 1'($urandom_range(0, 1)) : 1'(dmode);
                drive(1'b0, (p < 2) ? SA : ~SA, (ln < 2) ? SA : ~SA, r, g, b, d);
            end
        end
    endtask

    // Monitor
    initial begin
        logic [9:0] got, exp_v;
        int         due;
        forever begin
            @(posedge clk);
            #1;
            while (due_q.size() > 0 && due_q[0] <= cyc) begin
                due   = due_q.pop_front();
                exp_v = exp_q.pop_front();
                got   = {VGA_HSYNC, VGA_VSYNC, VGA_RED, VGA_GREEN, VGA_BLUE};
                n_cmp++;
                if (due != cyc || got !== exp_v) begin
                    n_bad++;
                    $display("FAIL out_pixel cyc=%0d due=%0d got hs=%b vs=%b r=%0d g=%0d b=%0d exp hs=%b vs=%b r=%0d g=%0d b=%0d",
                             cyc, due, got[9], got[8], got[7:5], got[4:2], got[1:0],
                             exp_v[9], exp_v[8], exp_v[7:5], exp_v[4:2], exp_v[1:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0] r, g, b;
        int         waited;
        repeat (3) begin
            pick_colour(5, r, g, b);
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, g, b, 1'b1);
        end
        frame(0, 1, 8);
        frame(1, 1, 8);
        frame(2, 1, 8);
        frame(2, 0, 8);
        frame(3, 0, 4);
        frame(3, 1, 4);
        frame(4, 1, 4);
        frame(5, 2, 8);
        // Arbitrary sync toggling with mid-grey colour
        for (int i = 0; i < 200; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'h80, 8'h80, 8'h80, 1'($urandom_range(0, 1)));
        // Reset in the middle of a frame, with pixels still in the pipeline
        frame(5, 2, 3);
        drive(1'b1, ~SA, ~SA, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        drive(1'b0, ~SA, ~SA, 8'h70, 8'hA0, 8'hB0, 1'b1);
        drive(1'b1, SA, SA, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        drive(1'b0, SA, ~SA, 8'h10, 8'h10, 8'h20, 1'b1);
        frame(5, 2, 8);
        // Drain with a bounded wait
        waited = 0;
        while (due_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (due_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", due_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
